tmds_encoder_3ch: RTL



---
 rtl/tmds_pkg.sv | 35 +++
 rtl/tmds_channel_encoder.sv | 98 +++++++++
 rtl/tmds_encoder_3ch.sv | 55 +++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, control tokens, disparity type and
// small helpers used by every channel encoder.
package tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  // Running disparity; stays within -8..+8, so 5 signed bits never wrap.
  typedef logic signed [4:0] disparity_t;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c1c0);
    logic [SYM_W-1:0] tok;
    case (c1c0)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: transition-minimising stage followed by DC-balancing stage
// with its own running-disparity counter. Two clocks of latency.
module tmds_channel_encoder
  import tmds_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       data_i,
  input  logic             blank_i,
  input  logic [1:0]       c1c0_i,
  output logic [SYM_W-1:0] sym_o
);

  logic [3:0]       n1_in;
  logic             use_xnor;
  logic [8:0]       qm_d;

  logic [8:0]       qm_p1_q;
  logic             blank_p1_q;
  logic [1:0]       c1c0_p1_q;

  logic [3:0]       n1_qm;
  logic [3:0]       n0_qm;
  disparity_t       diff;
  logic             q8;
  logic [SYM_W-1:0] sym_d;
  disparity_t       cnt_d;

  logic [SYM_W-1:0] sym_p2_q;
  disparity_t       cnt_q;

  // ---- stage 1: choose XOR/XNOR chain to minimise transitions ----

  // Build q_m; XNOR when the byte is ones-heavy (ties broken by bit 0).
  always_comb begin
    n1_in    = popcount8(data_i);
    use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !data_i[0]);
    qm_d     = '0;
    qm_d[0]  = data_i[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data_i[i]) : (qm_d[i-1] ^ data_i[i]);
    end
    qm_d[8]  = ~use_xnor;
  end

  // Stage-1 register; resets to a blanking cycle so the lane emits tokens.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qm_p1_q    <= '0;
      blank_p1_q <= 1'b1;
      c1c0_p1_q  <= 2'b00;
    end else begin
      qm_p1_q    <= qm_d;
      blank_p1_q <= blank_i;
      c1c0_p1_q  <= c1c0_i;
    end
  end

  // ---- stage 2: DC balancing against the running disparity ----

  // Pick the inversion that pulls cnt back towards zero, or emit a token.
  always_comb begin
    n1_qm = popcount8(qm_p1_q[7:0]);
    n0_qm = 4'd8 - n1_qm;
    diff  = $signed({1'b0, n1_qm}) - $signed({1'b0, n0_qm});
    q8    = qm_p1_q[8];
    sym_d = ctrl_token(c1c0_p1_q);
    cnt_d = '0;
    if (blank_p1_q) begin
      sym_d = ctrl_token(c1c0_p1_q);
      cnt_d = '0;
    end else if ((cnt_q == 5'sd0) || (n1_qm == n0_qm)) begin
      sym_d = {~q8, q8, (q8 ? qm_p1_q[7:0] : ~qm_p1_q[7:0])};
      cnt_d = q8 ? (cnt_q + diff) : (cnt_q - diff);
    end else if (((cnt_q > 5'sd0) && (n1_qm > n0_qm)) ||
                 ((cnt_q < 5'sd0) && (n0_qm > n1_qm))) begin
      sym_d = {1'b1, q8, ~qm_p1_q[7:0]};
      cnt_d = cnt_q + (q8 ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym_d = {1'b0, q8, qm_p1_q[7:0]};
      cnt_d = cnt_q + diff - (q8 ? 5'sd0 : 5'sd2);
    end
  end

  // Stage-2 register: output symbol and disparity counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sym_p2_q <= CTRL_TOKEN_00;
      cnt_q    <= '0;
    end else begin
      sym_p2_q <= sym_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sym_o = sym_p2_q;

endmodule

// File: rtl/tmds_encoder_3ch.sv
// Three-lane DVI/HDMI TMDS encoder: blue+syncs on lane 0, green on lane 1,
// red on lane 2. Only sync polarity and control routing live here.
module tmds_encoder_3ch
  import tmds_pkg::*;
#(
  parameter bit SYNC_INVERT = 1'b0
) (
  input  logic             CLK_PIXEL_I,
  input  logic             RESET_N_I,
  input  logic [7:0]       R_I,
  input  logic [7:0]       G_I,
  input  logic [7:0]       B_I,
  input  logic             BLANK_I,
  input  logic             HSYNC_I,
  input  logic             VSYNC_I,
  output logic [SYM_W-1:0] TMDS_D0_O,
  output logic [SYM_W-1:0] TMDS_D1_O,
  output logic [SYM_W-1:0] TMDS_D2_O
);

  logic hsync;
  logic vsync;

  // Negative-polarity sources are flipped so C0/C1 are always active-high.
  assign hsync = HSYNC_I ^ SYNC_INVERT;
  assign vsync = VSYNC_I ^ SYNC_INVERT;

  tmds_channel_encoder u_ch0 (
    .clk_i   (CLK_PIXEL_I),
    .rst_ni  (RESET_N_I),
    .data_i  (B_I),
    .blank_i (BLANK_I),
    .c1c0_i  ({vsync, hsync}),
    .sym_o   (TMDS_D0_O)
  );

  tmds_channel_encoder u_ch1 (
    .clk_i   (CLK_PIXEL_I),
    .rst_ni  (RESET_N_I),
    .data_i  (G_I),
    .blank_i (BLANK_I),
    .c1c0_i  (2'b00),
    .sym_o   (TMDS_D1_O)
  );

  tmds_channel_encoder u_ch2 (
    .clk_i   (CLK_PIXEL_I),
    .rst_ni  (RESET_N_I),
    .data_i  (R_I),
    .blank_i (BLANK_I),
    .c1c0_i  (2'b00),
    .sym_o   (TMDS_D2_O)
  );

endmodule
